fetch_unit: RTL

Instruction fetch stage for the single-cycle MIPS processor. It sits directly upstream of the instruction decoder/control block. It owns the PC and drives a request/acknowledge read of instruction memory. It holds the fetched word stable on `instruction` until the datapath retires it, then computes the next PC from the decoder's jump/branch outputs and the branch condition.

---
 rtl/fetch_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per request/ack handshake
// and holds it on `instruction` until the datapath retires it.
module fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instruction,
   output logic              instr_valid,
   input  logic              retire,
   input  logic              is_jump,
   input  logic              is_branch,
   input  logic              branch_taken,
   input  logic [25:0]       addr26,
   input  logic [15:0]       imm16,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       retired_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] branch_off;
   logic [ADDR_W-1:0] jump_target;

   assign pc_plus4    = pc + ADDR_W'(4);
   assign imem_addr   = pc;
   assign imem_req    = (state == FETCH);
   assign branch_off  = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
   assign jump_target = {pc_plus4[ADDR_W-1:28], addr26, 2'b00};

   // Jump beats branch; branch_taken only matters for a branch.
   always_comb begin
      next_pc = pc_plus4;
      if (is_jump) begin
         next_pc = jump_target;
      end else if (is_branch && branch_taken) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   // Acks outside FETCH and retires outside HOLD fall through untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         instruction   <= '0;
         instr_valid   <= 1'b0;
         retired_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  instruction <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (retire) begin
                  pc            <= next_pc;
                  instruction   <= '0;
                  instr_valid   <= 1'b0;
                  retired_count <= retired_count + 32'd1;
                  state         <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
